// File: rtl/score_pkg.sv
// score_pkg: shared types, constants and lookup tables for the score scheduler.
package score_pkg;

    // Scoring event classes; numeric order equals grant priority (highest last).
    typedef enum logic [1:0] {
        HIT   = 2'd0,
        BHIT  = 2'd1,
        KILL  = 2'd2,
        BKILL = 2'd3
    } score_class_e;

    // Accumulator sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        SAT   = 2'd2
    } score_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Increment table: amount a class adds to its target digit.
    function automatic logic [1:0] class_inc(input score_class_e cls);
        logic [1:0] inc;
        case (cls)
            HIT:     inc = 2'd1;
            BHIT:    inc = 2'd2;
            KILL:    inc = 2'd1;
            BKILL:   inc = 2'd1;
            default: inc = 2'd0;
        endcase
        return inc;
    endfunction

    // Target-digit table: which BCD digit a class lands on.
    function automatic logic [1:0] class_tgt(input score_class_e cls);
        logic [1:0] tgt;
        case (cls)
            HIT:     tgt = 2'd0;
            BHIT:    tgt = 2'd0;
            KILL:    tgt = 2'd2;
            BKILL:   tgt = 2'd3;
            default: tgt = 2'd0;
        endcase
        return tgt;
    endfunction

    // Packed 4-digit BCD values order the same way as their binary image.
    function automatic logic bcd4_gt(input logic [15:0] a, input logic [15:0] b);
        return (a > b);
    endfunction

endpackage

// File: rtl/score_bcd_digit.sv
// score_bcd_digit: adds 0..2 to one BCD digit, wrapping past 9 with a carry-out.
module score_bcd_digit
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [1:0] inc,
    output logic [3:0] sum,
    output logic       carry
);

    logic [4:0] raw_s;

    // Binary add then fold back into 0..9.
    always_comb begin
        raw_s = {1'b0, digit} + {3'b000, inc};
        if (raw_s > {1'b0, BCD_MAX}) begin
            sum   = raw_s[3:0] - 4'd10;
            carry = 1'b1;
        end else begin
            sum   = raw_s[3:0];
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/score_sched.sv
// score_sched: queues scoring events per class and adds them one at a time
// into a 4-digit BCD score, rippling carries one digit per clock.
// Optional feature: define SCORE_HISCORE_EN to add the high-score register.
module score_sched
    import score_pkg::*;
#(
    parameter int PEND_W = 3
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic       shot_enm,
    input  logic       shot_boss,
    input  logic       shot_reimu,
    input  logic [6:0] enmhp1,
    input  logic [6:0] enmhp2,
    input  logic [6:0] enmhp3,
    input  logic [6:0] enmhp4,
    input  logic [9:0] bosshp,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic       busy
`ifdef SCORE_HISCORE_EN
    ,
    output logic [3:0] hiscore0,
    output logic [3:0] hiscore1,
    output logic [3:0] hiscore2,
    output logic [3:0] hiscore3
`endif
);

    localparam int SUM_W = PEND_W + 3;
    localparam logic [SUM_W-1:0] PEND_SAT = {3'b000, {PEND_W{1'b1}}};

    score_state_e      state_r, state_s;
    logic [1:0]        idx_r, idx_s;
    bcd_t              score_r [4];
    bcd_t              score_s [4];
    logic [PEND_W-1:0] pend_r [4];
    logic [PEND_W-1:0] pend_s [4];
    logic [SUM_W-1:0]  pend_sum_s [4];
    logic [2:0]        evt_inc_s [4];
    logic [4:0]        dead_r, hp_zero_s, kill_s;
    logic [2:0]        kill_cnt_s;
    logic              busy_r, busy_s;
    logic [3:0]        grant_oh_s;
    logic              grant_vld_s;
    score_class_e      grant_cls_s;
    logic [1:0]        add_sel_s, add_inc_s;
    bcd_t              add_in_s, add_sum_s;
    logic              add_carry_s;
    logic              at_max_s;

    assign score0 = score_r[0];
    assign score1 = score_r[1];
    assign score2 = score_r[2];
    assign score3 = score_r[3];
    assign busy   = busy_r;

    // Kill = HP reads zero while the target was last seen alive.
    always_comb begin
        hp_zero_s[0] = (enmhp1 == 7'd0);
        hp_zero_s[1] = (enmhp2 == 7'd0);
        hp_zero_s[2] = (enmhp3 == 7'd0);
        hp_zero_s[3] = (enmhp4 == 7'd0);
        hp_zero_s[4] = (bosshp == 10'd0);
        kill_s       = hp_zero_s & ~dead_r;
        kill_cnt_s   = {2'b00, kill_s[0]} + {2'b00, kill_s[1]}
                     + {2'b00, kill_s[2]} + {2'b00, kill_s[3]};
    end

    // Per-class arrivals this cycle.
    always_comb begin
        evt_inc_s[HIT]   = {2'b00, shot_enm};
        evt_inc_s[BHIT]  = {2'b00, shot_boss};
        evt_inc_s[KILL]  = kill_cnt_s;
        evt_inc_s[BKILL] = {2'b00, kill_s[4]};
    end

    // Fixed-priority grant, only while no carry or saturation is in flight.
    always_comb begin
        grant_oh_s  = 4'b0000;
        grant_cls_s = HIT;
        if (state_r != IDLE) begin
            grant_oh_s = 4'b0000;
        end else if (pend_r[BKILL] != {PEND_W{1'b0}}) begin
            grant_oh_s  = 4'b1000;
            grant_cls_s = BKILL;
        end else if (pend_r[KILL] != {PEND_W{1'b0}}) begin
            grant_oh_s  = 4'b0100;
            grant_cls_s = KILL;
        end else if (pend_r[BHIT] != {PEND_W{1'b0}}) begin
            grant_oh_s  = 4'b0010;
            grant_cls_s = BHIT;
        end else if (pend_r[HIT] != {PEND_W{1'b0}}) begin
            grant_oh_s  = 4'b0001;
            grant_cls_s = HIT;
        end else begin
            grant_oh_s = 4'b0000;
        end
        grant_vld_s = |grant_oh_s;
    end

    // Score pinned at 9999 swallows further grants.
    always_comb begin
        at_max_s = (score_r[0] == BCD_MAX) && (score_r[1] == BCD_MAX)
                && (score_r[2] == BCD_MAX) && (score_r[3] == BCD_MAX);
    end

    // Select the digit and amount fed to the shared BCD adder.
    always_comb begin
        add_sel_s = 2'd0;
        add_inc_s = 2'd0;
        case (state_r)
            IDLE: begin
                add_sel_s = class_tgt(grant_cls_s);
                add_inc_s = class_inc(grant_cls_s);
            end
            CARRY: begin
                add_sel_s = idx_r;
                add_inc_s = 2'd1;
            end
            default: begin
                add_sel_s = 2'd0;
                add_inc_s = 2'd0;
            end
        endcase
        add_in_s = score_r[add_sel_s];
    end

    score_bcd_digit u_add (
        .digit (add_in_s),
        .inc   (add_inc_s),
        .sum   (add_sum_s),
        .carry (add_carry_s)
    );

    // Next FSM state, carry index and score digits.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        score_s = score_r;
        if (shot_reimu) begin
            state_s = IDLE;
            idx_s   = 2'd0;
            for (int d = 0; d < 4; d++) begin
                score_s[d] = 4'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s && !at_max_s) begin
                        if (!add_carry_s) begin
                            score_s[add_sel_s] = add_sum_s;
                        end else if (add_sel_s == 2'd3) begin
                            // Thousands overflow: digit holds 9 until SAT fills the rest.
                            state_s = SAT;
                        end else begin
                            score_s[add_sel_s] = add_sum_s;
                            idx_s              = add_sel_s + 2'd1;
                            state_s            = CARRY;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CARRY: begin
                    if (!add_carry_s) begin
                        score_s[idx_r] = add_sum_s;
                        state_s        = IDLE;
                    end else if (idx_r == 2'd3) begin
                        state_s = SAT;
                    end else begin
                        score_s[idx_r] = add_sum_s;
                        idx_s          = idx_r + 2'd1;
                    end
                end
                SAT: begin
                    state_s = IDLE;
                    for (int d = 0; d < 4; d++) begin
                        score_s[d] = BCD_MAX;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Pending counters: arrivals minus grant, saturating at the top.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            pend_sum_s[c] = {3'b000, pend_r[c]} + {{PEND_W{1'b0}}, evt_inc_s[c]}
                          - {{(SUM_W-1){1'b0}}, grant_oh_s[c]};
            if (shot_reimu) begin
                pend_s[c] = {PEND_W{1'b0}};
            end else if (pend_sum_s[c] > PEND_SAT) begin
                pend_s[c] = {PEND_W{1'b1}};
            end else begin
                pend_s[c] = pend_sum_s[c][PEND_W-1:0];
            end
        end
    end

    // Busy reflects the state the block is about to be in.
    always_comb begin
        busy_s = (state_s != IDLE)
              || (pend_s[0] != {PEND_W{1'b0}}) || (pend_s[1] != {PEND_W{1'b0}})
              || (pend_s[2] != {PEND_W{1'b0}}) || (pend_s[3] != {PEND_W{1'b0}});
    end

    // Core state registers; reset and game start clear everything.
    always_ff @(posedge clk22) begin
        if (rst || gamestart) begin
            state_r <= IDLE;
            idx_r   <= 2'd0;
            busy_r  <= 1'b0;
            for (int d = 0; d < 4; d++) begin
                score_r[d] <= 4'd0;
                pend_r[d]  <= {PEND_W{1'b0}};
            end
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            for (int d = 0; d < 4; d++) begin
                score_r[d] <= score_s[d];
                pend_r[d]  <= pend_s[d];
            end
        end
    end

    // Dead flags start set so a target must come alive before its death scores.
    always_ff @(posedge clk22) begin
        if (rst || gamestart) begin
            dead_r <= 5'b11111;
        end else begin
            dead_r <= hp_zero_s;
        end
    end

`ifdef SCORE_HISCORE_EN
    bcd_t hi_r [4];
    logic hi_upd_s;

    assign hiscore0 = hi_r[0];
    assign hiscore1 = hi_r[1];
    assign hiscore2 = hi_r[2];
    assign hiscore3 = hi_r[3];

    // Capture a settled score that beats the record (pre-clear on player hit).
    always_comb begin
        hi_upd_s = (state_r == IDLE)
                && bcd4_gt({score_r[3], score_r[2], score_r[1], score_r[0]},
                           {hi_r[3], hi_r[2], hi_r[1], hi_r[0]});
    end

    // High-score register survives game start; only reset clears it.
    always_ff @(posedge clk22) begin
        if (rst) begin
            for (int d = 0; d < 4; d++) begin
                hi_r[d] <= 4'd0;
            end
        end else if (gamestart) begin
            for (int d = 0; d < 4; d++) begin
                hi_r[d] <= hi_r[d];
            end
        end else if (hi_upd_s) begin
            for (int d = 0; d < 4; d++) begin
                hi_r[d] <= score_r[d];
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                hi_r[d] <= hi_r[d];
            end
        end
    end
`endif

endmodule

// File: tb/tb_score_sched.sv
// tb_score_sched: directed scenarios plus random traffic against a
// behavioural score model; every clock's outputs are compared.
module tb_score_sched;

    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       gamestart = 1'b0;
    logic       shot_enm = 1'b0;
    logic       shot_boss = 1'b0;
    logic       shot_reimu = 1'b0;
    logic [6:0] ehp [4];
    logic [9:0] bosshp = 10'd0;
    logic [3:0] score0, score1, score2, score3;
    logic       busy;
`ifdef SCORE_HISCORE_EN
    logic [3:0] hiscore0, hiscore1, hiscore2, hiscore3;
`endif

    int total = 0;
    int bad = 0;

    localparam int M_IDLE = 0;
    localparam int M_CARRY = 1;
    localparam int M_SAT = 2;
    localparam int PEND_MAX = 7;

    int m_sc [4];
    int m_hi [4];
    int m_pend [4];
    bit m_dead [5];
    int m_mode;
    int m_idx;
    bit m_busy;
    int inc_tab [4] = '{1, 2, 1, 1};
    int tgt_tab [4] = '{0, 0, 2, 3};

    score_sched dut (
        .clk22      (clk22),
        .rst        (rst),
        .gamestart  (gamestart),
        .shot_enm   (shot_enm),
        .shot_boss  (shot_boss),
        .shot_reimu (shot_reimu),
        .enmhp1     (ehp[0]),
        .enmhp2     (ehp[1]),
        .enmhp3     (ehp[2]),
        .enmhp4     (ehp[3]),
        .bosshp     (bosshp),
        .score0     (score0),
        .score1     (score1),
        .score2     (score2),
        .score3     (score3),
        .busy       (busy)
`ifdef SCORE_HISCORE_EN
        ,
        .hiscore0   (hiscore0),
        .hiscore1   (hiscore1),
        .hiscore2   (hiscore2),
        .hiscore3   (hiscore3)
`endif
    );

    always #5 clk22 = ~clk22;

    function automatic int val4(input int d0, input int d1, input int d2, input int d3);
        return d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    endfunction

    function automatic logic [15:0] dut_hex();
        return {score3, score2, score1, score0};
    endfunction

    function automatic logic [15:0] exp_hex();
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            h[i*4 +: 4] = 4'(m_sc[i]);
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advance one clock from the inputs currently applied.
    task automatic model_step();
        int hpv [5];
        int evt [4];
        int g;
        int t;
        int v;
        int cur;
        for (int i = 0; i < 4; i++) hpv[i] = int'(ehp[i]);
        hpv[4] = int'(bosshp);
        if (rst || gamestart) begin
            for (int i = 0; i < 4; i++) begin
                m_sc[i] = 0;
                m_pend[i] = 0;
                if (rst) m_hi[i] = 0;
            end
            for (int i = 0; i < 5; i++) m_dead[i] = 1'b1;
            m_mode = M_IDLE;
            m_idx = 0;
            m_busy = 1'b0;
        end else begin
            evt[0] = int'(shot_enm);
            evt[1] = int'(shot_boss);
            evt[2] = 0;
            evt[3] = 0;
            for (int i = 0; i < 4; i++) if (!m_dead[i] && hpv[i] == 0) evt[2]++;
            if (!m_dead[4] && hpv[4] == 0) evt[3] = 1;
            for (int i = 0; i < 5; i++) m_dead[i] = (hpv[i] == 0);
            cur = val4(m_sc[0], m_sc[1], m_sc[2], m_sc[3]);
            if (m_mode == M_IDLE && cur > val4(m_hi[0], m_hi[1], m_hi[2], m_hi[3]))
                for (int i = 0; i < 4; i++) m_hi[i] = m_sc[i];
            if (shot_reimu) begin
                for (int i = 0; i < 4; i++) begin
                    m_sc[i] = 0;
                    m_pend[i] = 0;
                end
                m_mode = M_IDLE;
            end else begin
                g = -1;
                if (m_mode == M_IDLE)
                    for (int c = 3; c >= 0; c--) if (g < 0 && m_pend[c] > 0) g = c;
                if (m_mode == M_IDLE) begin
                    if (g >= 0 && cur != 9999) begin
                        t = tgt_tab[g];
                        v = m_sc[t] + inc_tab[g];
                        if (v <= 9) m_sc[t] = v;
                        else if (t == 3) m_mode = M_SAT;
                        else begin
                            m_sc[t] = v - 10;
                            m_idx = t + 1;
                            m_mode = M_CARRY;
                        end
                    end
                end else if (m_mode == M_CARRY) begin
                    v = m_sc[m_idx] + 1;
                    if (v <= 9) begin
                        m_sc[m_idx] = v;
                        m_mode = M_IDLE;
                    end else if (m_idx == 3) m_mode = M_SAT;
                    else begin
                        m_sc[m_idx] = v - 10;
                        m_idx++;
                    end
                end else begin
                    for (int i = 0; i < 4; i++) m_sc[i] = 9;
                    m_mode = M_IDLE;
                end
                for (int c = 0; c < 4; c++) begin
                    m_pend[c] = m_pend[c] + evt[c] - ((g == c) ? 1 : 0);
                    if (m_pend[c] > PEND_MAX) m_pend[c] = PEND_MAX;
                end
            end
            m_busy = (m_mode != M_IDLE);
            for (int c = 0; c < 4; c++) if (m_pend[c] > 0) m_busy = 1'b1;
        end
    endtask

    // One clock: model, edge, then compare all outputs against the model.
    task automatic tick();
        model_step();
        @(posedge clk22);
        #1;
        chk("score", dut_hex(), exp_hex());
        chk("busy", {15'd0, busy}, {15'd0, m_busy});
`ifdef SCORE_HISCORE_EN
        chk("hiscore", {hiscore3, hiscore2, hiscore1, hiscore0},
            {4'(m_hi[3]), 4'(m_hi[2]), 4'(m_hi[1]), 4'(m_hi[0])});
`endif
    endtask

    task automatic pulse(input bit e, input bit b, input bit r);
        shot_enm = e;
        shot_boss = b;
        shot_reimu = r;
        tick();
        shot_enm = 1'b0;
        shot_boss = 1'b0;
        shot_reimu = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy && n < 200) begin
            tick();
            n++;
        end
        if (m_busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    task automatic restart(input bit full);
        if (full) rst = 1'b1;
        else gamestart = 1'b1;
        tick();
        rst = 1'b0;
        gamestart = 1'b0;
    endtask

    task automatic kill_enm(input int n);
        for (int i = 0; i < n; i++) ehp[i] = 7'd5;
        tick();
        for (int i = 0; i < n; i++) ehp[i] = 7'd0;
        tick();
    endtask

    task automatic kill_boss();
        bosshp = 10'd1;
        tick();
        bosshp = 10'd0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) ehp[i] = 7'd0;
        restart(1'b1);
        chk("reset_score", dut_hex(), 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);

        // Single hit: pending after one edge, score the next.
        pulse(1'b1, 1'b0, 1'b0);
        chk("hit_busy_rise", {15'd0, busy}, 16'd1);
        tick();
        chk("hit_score", dut_hex(), 16'h0001);
        chk("hit_busy_fall", {15'd0, busy}, 16'd0);

        // Climb to 0099, then ripple two carries.
        for (int i = 0; i < 49; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            drain();
        end
        chk("score_0099", dut_hex(), 16'h0099);
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        chk("carry_add", dut_hex(), 16'h0090);
        tick();
        chk("carry_mid", dut_hex(), 16'h0000);
        tick();
        chk("carry_done", dut_hex(), 16'h0100);
        drain();

        // Four simultaneous enemy kills.
        restart(1'b0);
        kill_enm(4);
        tick();
        chk("kill4_first", dut_hex(), 16'h0100);
        drain();
        chk("kill4_final", dut_hex(), 16'h0400);

        // Boss hit and boss kill together: kill is granted first.
        restart(1'b0);
        bosshp = 10'd1;
        tick();
        bosshp = 10'd0;
        pulse(1'b0, 1'b1, 1'b0);
        tick();
        chk("bkill_first", dut_hex(), 16'h1000);
        tick();
        chk("bhit_second", dut_hex(), 16'h1002);
        drain();

        // Reset while a carry is in flight.
        restart(1'b0);
        for (int i = 0; i < 9; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            drain();
        end
        pulse(1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_carry", dut_hex(), 16'h0010);
        restart(1'b1);
        chk("rst_mid_carry", dut_hex(), 16'h0000);
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        tick();
        chk("rst_no_late_carry", dut_hex(), 16'h0000);

        // Build 9998, then two boss hits saturate at 9999.
        restart(1'b0);
        for (int i = 0; i < 9; i++) begin
            kill_boss();
            drain();
        end
        for (int i = 0; i < 9; i++) begin
            kill_enm(1);
            drain();
        end
        for (int i = 0; i < 49; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            drain();
        end
        chk("score_9998", dut_hex(), 16'h9998);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        drain();
        chk("sat_score", dut_hex(), 16'h9999);
        chk("sat_busy", {15'd0, busy}, 16'd0);

        // Player hit with a same-cycle hit after reaching 0450 (record 0300).
        restart(1'b1);
        kill_enm(3);
        drain();
        tick();
`ifdef SCORE_HISCORE_EN
        chk("hi_0300", {hiscore3, hiscore2, hiscore1, hiscore0}, 16'h0300);
`endif
        restart(1'b0);
        kill_enm(4);
        drain();
        for (int i = 0; i < 25; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            drain();
        end
        chk("score_0450", dut_hex(), 16'h0450);
        pulse(1'b1, 1'b0, 1'b1);
        chk("reimu_clear", dut_hex(), 16'h0000);
`ifdef SCORE_HISCORE_EN
        chk("hi_0450", {hiscore3, hiscore2, hiscore1, hiscore0}, 16'h0450);
`endif
        tick();
        tick();
        chk("reimu_dropped", dut_hex(), 16'h0000);
        chk("reimu_busy", {15'd0, busy}, 16'd0);

        // Burst that saturates the HIT counter.
        restart(1'b0);
        shot_enm = 1'b1;
        shot_boss = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        shot_enm = 1'b0;
        shot_boss = 1'b0;
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            shot_enm = ($urandom_range(0, 99) < 20);
            shot_boss = ($urandom_range(0, 9) == 0);
            shot_reimu = ($urandom_range(0, 299) == 0);
            gamestart = ($urandom_range(0, 599) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 5) == 0)
                    ehp[k] = ($urandom_range(0, 1) == 1) ? 7'd0 : 7'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0)
                bosshp = ($urandom_range(0, 1) == 1) ? 10'd0 : 10'($urandom_range(1, 1023));
            tick();
        end
        shot_enm = 1'b0;
        shot_boss = 1'b0;
        shot_reimu = 1'b0;
        gamestart = 1'b0;
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
